// File: rtl/decision_tree_pkg.sv
// decision_tree_pkg: shared types, node word layout helpers and legacy class codes
package decision_tree_pkg;
  typedef enum logic {IDLE, WALK} state_t;
  localparam logic [7:0] CLS_Y1 = 8'd1;
  localparam logic [7:0] CLS_Y2 = 8'd2;
  localparam logic [7:0] CLS_Y3 = 8'd3;
  localparam logic [7:0] CLS_Y4 = 8'd4;
  function automatic int idx_w(int n);
    return n > 2 ? $clog2(n) : 1;
  endfunction
  function automatic int off_left(int aw);
    return aw;
  endfunction
  function automatic int off_thresh(int aw);
    return 2 * aw;
  endfunction
  function automatic int off_fidx(int aw, int fw);
    return 2 * aw + fw;
  endfunction
  function automatic int node_w(int fw, int fiw, int aw);
    return 1 + fiw + fw + 2 * aw;
  endfunction
endpackage

// File: rtl/dt_node_eval.sv
// dt_node_eval: decodes one node word against the latched features
module dt_node_eval import decision_tree_pkg::*; #(
  parameter int FEAT_W = 8,
  parameter int N_FEAT = 4,
  parameter int N_NODES = 16,
  parameter int CLASS_W = 8,
  localparam int FIDX_W = idx_w(N_FEAT),
  localparam int ADDR_W = idx_w(N_NODES),
  localparam int NODE_W = node_w(FEAT_W, FIDX_W, ADDR_W)
) (
  input  logic [NODE_W-1:0]        node,
  input  logic [N_FEAT*FEAT_W-1:0] feat,
  output logic                     is_leaf,
  output logic [CLASS_W-1:0]       cls,
  output logic [ADDR_W-1:0]        nxt,
  output logic                     err
);
  logic [FIDX_W-1:0] fidx;
  logic [FEAT_W-1:0] thr;
  logic [FEAT_W-1:0] fv;
  logic [ADDR_W-1:0] left;
  logic [ADDR_W-1:0] right;
  assign is_leaf = node[NODE_W-1];
  assign fidx = node[off_fidx(ADDR_W, FEAT_W) +: FIDX_W];
  assign thr = node[off_thresh(ADDR_W) +: FEAT_W];
  assign left = node[off_left(ADDR_W) +: ADDR_W];
  assign right = node[ADDR_W-1:0];
  assign cls = thr[CLASS_W-1:0];
  assign nxt = fv < thr ? left : right;
  assign err = !is_leaf && (32'(fidx) >= N_FEAT || 32'(nxt) >= N_NODES);
  always_comb begin
    fv = '0;
    for (int k = 0; k < N_FEAT; k++)
      fv = 32'(fidx) == k ? feat[k*FEAT_W +: FEAT_W] : fv;
  end
endmodule

// File: rtl/decision_tree_engine.sv
// decision_tree_engine: run-time programmable binary decision-tree classifier
module decision_tree_engine import decision_tree_pkg::*; #(
  parameter int FEAT_W = 8,
  parameter int N_FEAT = 4,
  parameter int N_NODES = 16,
  parameter int CLASS_W = 8,
  parameter int MAX_LEVELS = 8,
  localparam int FIDX_W = idx_w(N_FEAT),
  localparam int ADDR_W = idx_w(N_NODES),
  localparam int NODE_W = node_w(FEAT_W, FIDX_W, ADDR_W),
  localparam int LVL_W = idx_w(MAX_LEVELS)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start_i,
  input  logic [N_FEAT*FEAT_W-1:0] feat_i,
  input  logic                     cfg_we_i,
  input  logic [ADDR_W-1:0]        cfg_addr_i,
  input  logic [NODE_W-1:0]        cfg_data_i,
  output logic [CLASS_W-1:0]       y_o,
  output logic                     y_valid_o,
  output logic                     err_o,
  output logic                     busy_o
);
  localparam logic [NODE_W-1:0] LEAF0 = {1'b1, {(NODE_W-1){1'b0}}};
  state_t state;
  logic [NODE_W-1:0] tbl [N_NODES];
  logic [N_FEAT*FEAT_W-1:0] feat_q;
  logic [ADDR_W-1:0] node;
  logic [LVL_W-1:0] level;
  logic is_leaf;
  logic ev_err;
  logic [CLASS_W-1:0] cls;
  logic [ADDR_W-1:0] nxt;
  dt_node_eval #(
    .FEAT_W(FEAT_W), .N_FEAT(N_FEAT), .N_NODES(N_NODES), .CLASS_W(CLASS_W)
  ) u_eval (
    .node(tbl[node]), .feat(feat_q), .is_leaf(is_leaf), .cls(cls), .nxt(nxt), .err(ev_err)
  );
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      y_o <= '0;
      y_valid_o <= 1'b0;
      err_o <= 1'b0;
      busy_o <= 1'b0;
      feat_q <= '0;
      node <= '0;
      level <= '0;
      for (int i = 0; i < N_NODES; i++)
        tbl[i] <= LEAF0;
    end else begin
      y_valid_o <= 1'b0;
      if (cfg_we_i && !busy_o && 32'(cfg_addr_i) < N_NODES)
        tbl[cfg_addr_i] <= cfg_data_i;
      if (state == IDLE) begin
        if (start_i) begin
          state <= WALK;
          busy_o <= 1'b1;
          err_o <= 1'b0;
          feat_q <= feat_i;
          node <= '0;
          level <= '0;
        end
      end else if (is_leaf || ev_err || level == LVL_W'(MAX_LEVELS - 1)) begin
        state <= IDLE;
        busy_o <= 1'b0;
        y_valid_o <= 1'b1;
        err_o <= !is_leaf;
        y_o <= is_leaf ? cls : '0;
      end else begin
        node <= nxt;
        level <= level + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_decision_tree_engine.sv
// tb_decision_tree_engine: vector table, corner sequences and random trees vs a walk model
module tb_decision_tree_engine;
  import decision_tree_pkg::*;
  localparam int NN = 12;
  localparam int NF = 3;
  localparam int ML = 8;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start_i = 1'b0;
  logic cfg_we_i = 1'b0;
  logic [23:0] feat_i = '0;
  logic [3:0] cfg_addr_i = '0;
  logic [18:0] cfg_data_i = '0;
  logic [7:0] y_o;
  logic y_valid_o;
  logic err_o;
  logic busy_o;
  int total = 0;
  int bad = 0;
  bit m_leaf [NN];
  int m_fidx [NN];
  int m_thr [NN];
  int m_l [NN];
  int m_r [NN];
  typedef struct {
    logic [23:0] f;
    int y;
    int e;
    int lat;
  } vec_t;
  vec_t v [6];
  always #5 clk = ~clk;
  decision_tree_engine #(
    .FEAT_W(8), .N_FEAT(NF), .N_NODES(NN), .CLASS_W(8), .MAX_LEVELS(ML)
  ) dut (
    .clk(clk), .reset(reset), .start_i(start_i), .feat_i(feat_i),
    .cfg_we_i(cfg_we_i), .cfg_addr_i(cfg_addr_i), .cfg_data_i(cfg_data_i),
    .y_o(y_o), .y_valid_o(y_valid_o), .err_o(err_o), .busy_o(busy_o)
  );
  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", nm, got, exp);
    end
  endtask
  task automatic clear_model();
    for (int i = 0; i < NN; i++) begin
      m_leaf[i] = 1'b1;
      m_fidx[i] = 0;
      m_thr[i] = 0;
      m_l[i] = 0;
      m_r[i] = 0;
    end
  endtask
  task automatic cfg(input int a, input bit lf, input int fi, input int th, input int l, input int r);
    @(negedge clk);
    cfg_we_i = 1'b1;
    cfg_addr_i = 4'(a);
    cfg_data_i = {lf, 2'(fi), 8'(th), 4'(l), 4'(r)};
    @(negedge clk);
    cfg_we_i = 1'b0;
    if (a < NN) begin
      m_leaf[a] = lf;
      m_fidx[a] = fi;
      m_thr[a] = th;
      m_l[a] = l;
      m_r[a] = r;
    end
  endtask
  task automatic load_legacy();
    cfg(0, 0, 0, 'h80, 1, 2);
    cfg(1, 0, 1, 'h40, 3, 4);
    cfg(2, 0, 2, 'h40, 5, 6);
    cfg(3, 1, 0, int'(CLS_Y1), 0, 0);
    cfg(4, 1, 0, int'(CLS_Y2), 0, 0);
    cfg(5, 1, 0, int'(CLS_Y3), 0, 0);
    cfg(6, 1, 0, int'(CLS_Y4), 0, 0);
  endtask
  function automatic void model(input logic [23:0] f, output int y, output int e, output int lat);
    int n = 0;
    y = 0;
    e = 1;
    lat = ML + 1;
    for (int d = 1; d <= ML; d++) begin
      int c;
      if (m_leaf[n]) begin
        y = m_thr[n];
        e = 0;
        lat = d + 1;
        return;
      end
      if (m_fidx[n] >= NF) begin
        lat = d + 1;
        return;
      end
      c = (int'(f[m_fidx[n]*8 +: 8]) < m_thr[n]) ? m_l[n] : m_r[n];
      if (c >= NN) begin
        lat = d + 1;
        return;
      end
      n = c;
    end
  endfunction
  task automatic go(input logic [23:0] f, output int y, output int e, output int lat);
    feat_i = f;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    lat = 1;
    check("busy_rise", busy_o, 1);
    check("err_clear", err_o, 0);
    while (!y_valid_o && lat < ML + 4) begin
      @(negedge clk);
      lat++;
    end
    if (!y_valid_o) check("valid_timeout", 0, 1);
    check("busy_fall", busy_o, 0);
    y = y_o;
    e = err_o;
  endtask
  task automatic apply(input string nm, input logic [23:0] f, input int ey, input int ee, input int el, input bit b2b);
    int y, e, l;
    if (!b2b) begin
      @(negedge clk);
      check({nm, "_vwidth"}, y_valid_o, 0);
    end
    go(f, y, e, l);
    check({nm, "_y"}, y, ey);
    check({nm, "_err"}, e, ee);
    check({nm, "_lat"}, l, el);
  endtask
  task automatic run_model(input string nm, input logic [23:0] f);
    int y, e, l;
    model(f, y, e, l);
    apply(nm, f, y, e, l, 1'b0);
  endtask
  initial begin
    int t;
    v[0] = '{{8'h00, 8'h10, 8'h10}, 1, 0, 4};
    v[1] = '{{8'h00, 8'h50, 8'h10}, 2, 0, 4};
    v[2] = '{{8'h10, 8'hAA, 8'h90}, 3, 0, 4};
    v[3] = '{{8'h90, 8'h33, 8'h90}, 4, 0, 4};
    v[4] = '{{8'h90, 8'h00, 8'h80}, 4, 0, 4};
    v[5] = '{{8'h00, 8'h3F, 8'h7F}, 1, 0, 4};
    repeat (3) @(negedge clk);
    check("rst_y", y_o, 0);
    check("rst_valid", y_valid_o, 0);
    check("rst_err", err_o, 0);
    check("rst_busy", busy_o, 0);
    reset = 1'b0;
    clear_model();
    apply("root_leaf", 24'h123456, 0, 0, 2, 1'b0);
    load_legacy();
    for (int i = 0; i < 6; i++)
      apply($sformatf("vec%0d", i), v[i].f, v[i].y, v[i].e, v[i].lat, 1'b0);
    apply("b2b_a", v[0].f, 1, 0, 4, 1'b0);
    apply("b2b_b", v[3].f, 4, 0, 4, 1'b1);
    @(negedge clk);
    feat_i = v[1].f;
    start_i = 1'b1;
    @(negedge clk);
    feat_i = v[3].f;
    cfg_we_i = 1'b1;
    cfg_addr_i = 4'd4;
    cfg_data_i = {1'b1, 2'd0, 8'd99, 4'd0, 4'd0};
    @(negedge clk);
    start_i = 1'b0;
    cfg_we_i = 1'b0;
    t = 2;
    while (!y_valid_o && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("mid_valid", y_valid_o, 1);
    check("mid_y", y_o, 2);
    check("mid_lat", t, 4);
    apply("mid_table", v[1].f, 2, 0, 4, 1'b0);
    for (int i = 0; i < 20; i++)
      run_model("rnd_legacy", 24'($urandom));
    cfg(0, 0, 0, 0, 0, 0);
    apply("self_loop", 24'($urandom), 0, 1, ML + 1, 1'b0);
    cfg(0, 0, 0, 'h80, 15, 15);
    apply("bad_child", 24'h000000, 0, 1, 2, 1'b0);
    cfg(0, 0, 3, 'h80, 1, 1);
    apply("bad_fidx", 24'h000000, 0, 1, 2, 1'b0);
    for (int r = 0; r < 8; r++) begin
      for (int a = 0; a < 14; a++)
        cfg(a, $urandom_range(0, 2) == 0, $urandom_range(0, 3), $urandom_range(0, 255),
            $urandom_range(0, 13), $urandom_range(0, 13));
      for (int i = 0; i < 5; i++)
        run_model("rnd_tree", 24'($urandom));
    end
    load_legacy();
    @(negedge clk);
    feat_i = v[0].f;
    start_i = 1'b1;
    @(negedge clk);
    start_i = 1'b0;
    @(negedge clk);
    check("rst_mid_busy_before", busy_o, 1);
    reset = 1'b1;
    @(negedge clk);
    check("rst_mid_busy", busy_o, 0);
    check("rst_mid_valid", y_valid_o, 0);
    reset = 1'b0;
    clear_model();
    @(negedge clk);
    check("rst_mid_novalid", y_valid_o, 0);
    apply("post_reset", v[3].f, 0, 0, 2, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
